uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter. Serialises one parallel byte per valid/ready handshake into an 8N1-style frame:
//  start bit (0), BIT_MAX data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
//  Pairs with the UART receiver on the same board link (same BPS_MAX/BIT_MAX settings).
//  Sits between the user logic/loopback path and the FPGA TX pin.
// PARAMETERS
//  BPS_MAX    5208  clocks per bit (50 MHz / 9600 baud); must be >= 2
//  BIT_MAX    8     data bits per frame (1..8)
//  PARITY_EN  0     1 = insert parity bit after data
//  PARITY_ODD 0     0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
//  STOP_BITS  1     number of stop bits (1 or 2)
// PORTS
//  clk       in   1        system clock, rising edge
//  rst       in   1        asynchronous active-low reset
//  tx_data   in   BIT_MAX  byte to send, sampled only on accept
//  tx_valid  in   1        request to send tx_data
//  tx_ready  out  1        1 = idle, can accept a byte this cycle
//  tx        out  1        serial line, registered, idles high
//  tx_done   out  1        one-cycle pulse at end of frame
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, tx=1, tx_ready=1, tx_done=0, counters=0, shift reg=0.
//  Reset mid-frame aborts immediately; tx returns high without waiting for a clock.
//  Accept = tx_valid & tx_ready at a rising edge; tx_data latched into an internal shift reg.
//  FSM: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//  - IDLE: tx=1, tx_ready=1. On accept: tx<=0 at the same edge, go START, bps_cnt<=0.
//  - Each bit holds tx for exactly BPS_MAX clocks; bps_cnt counts 0..BPS_MAX-1, wraps,
//    bit/state advances on the wrap edge.
//  - DATA: bit i (LSB first) driven for bit_cnt=0..BIT_MAX-1; after the last bit go to PARITY or STOP.
//  - PARITY: tx = ^data (even) or ~^data (odd), computed from the latched byte.
//  - STOP: tx=1 for STOP_BITS*BPS_MAX clocks.
//  Frame length N = (1 + BIT_MAX + PARITY_EN + STOP_BITS) * BPS_MAX clocks.
//  If accept happens at edge k: tx low from edge k; IDLE re-entered at edge k+N.
//  At edge k+N: tx_done=1 for exactly one cycle and tx_ready=1.
//  tx_ready=0 from edge k+1 through k+N-1.
//  Back-to-back: if tx_valid is held, the next byte is accepted at edge k+N+1
//  (1 clock idle-high gap minimum).
//  tx_valid while busy is ignored (not queued).
//  tx_data changes during a frame do not affect the frame in flight.
//  tx is a flop output (no combinational glitches on the pin).
// TESTING (bench uses BPS_MAX=4, BIT_MAX=8 unless noted)
//  1 Reset: rst=0 then release -> tx=1, tx_ready=1, tx_done=0; no activity while tx_valid=0.
//  2 Send 0xA5, 8N1 -> tx low 4 clk, then bits 1,0,1,0,0,1,0,1 at 4 clk each, high 4 clk;
//    tx_done pulse 40 clk after accept.
//  3 Hold tx_valid with 0x55 then 0x0F -> second start bit begins exactly 41 clk after the first;
//    loopback into uart receiver returns 0x55, 0x0F.
//  4 PARITY_EN=1, even: 0x07 -> parity bit 1; PARITY_ODD=1: 0x07 -> 0.
//    STOP_BITS=2 gives frame length 48 clk.
//  5 Pulse tx_valid with new tx_data mid-frame -> ignored; frame unchanged; tx_ready stays 0.
//  6 Assert rst during DATA bit 3 -> tx=1 asynchronously.
//    After release, a new accept of 0x3C sends a clean full frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as start bit, LSB-first data,
// optional parity and one or two stop bits. Every output is driven straight from a flop.
module uart_tx #(
    parameter int BPS_MAX    = 5208,
    parameter int BIT_MAX    = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIT_MAX-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx,
    output logic               tx_done
);

    localparam int CW  = $clog2(BPS_MAX);
    localparam int BCW = $clog2(BIT_MAX + 1);
    localparam logic [CW-1:0]  BPS_LAST  = CW'(BPS_MAX - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(BIT_MAX - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state;
    logic [CW-1:0]      bps_cnt;
    logic [BCW-1:0]     bit_cnt;
    logic [BIT_MAX-1:0] shreg;
    logic               parity_bit;
    logic               bit_end;

    assign bit_end = (bps_cnt == BPS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            bps_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                bps_cnt <= bit_end ? '0 : bps_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    // tx_ready is high throughout IDLE, so tx_valid alone means accept.
                    if (tx_valid) begin
                        shreg      <= tx_data;
                        parity_bit <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                        tx         <= 1'b0;
                        tx_ready   <= 1'b0;
                        bps_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // bit_cnt reused to count stop bits; the last wrap ends the frame.
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt  <= '0;
                            tx_ready <= 1'b1;
                            tx_done  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E1, 8O2) at 4 clocks per bit, driven from a
// table of frames with hand-written bit patterns plus back-to-back and mid-frame reset sequences.
module tb_uart_tx;

    localparam int BPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] valid_v = 3'b000;
    logic [7:0] data_v [3];
    logic [2:0] tx_w;
    logic [2:0] rdy_w;
    logic [2:0] done_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.BPS_MAX(BPS), .BIT_MAX(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n1 (
        .clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_done(done_w[0])
    );

    uart_tx #(.BPS_MAX(BPS), .BIT_MAX(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e1 (
        .clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_done(done_w[1])
    );

    uart_tx #(.BPS_MAX(BPS), .BIT_MAX(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o2 (
        .clk(clk), .rst(rst), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_done(done_w[2])
    );

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [15:0] bits;   // bit i = i-th bit on the line (start first)
        int          nbits;
        int          poke;   // >0: pulse tx_valid with other data at this cycle of the frame
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Accept at the posedge after the call; then check every cycle of the frame and the done pulse.
    task automatic send_frame(input int s, input logic [7:0] d, input logic [15:0] bits,
                              input int nbits, input int poke, input string name);
        int n;
        n = nbits * BPS;
        @(negedge clk);
        chk({name, "_rdy_pre"}, 0, 32'(rdy_w[s]), 32'd1);
        valid_v[s] = 1'b1;
        data_v[s]  = d;
        @(posedge clk);
        @(negedge clk);
        valid_v[s] = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (poke > 0 && j == poke) begin
                valid_v[s] = 1'b1;
                data_v[s]  = ~d;
            end else if (poke > 0 && j == poke + 1) begin
                valid_v[s] = 1'b0;
            end
            chk({name, "_tx"}, j, 32'(tx_w[s]), 32'(bits[j / BPS]));
            chk({name, "_done"}, j, 32'(done_w[s]), 32'd0);
            if (j >= 1) chk({name, "_rdy"}, j, 32'(rdy_w[s]), 32'd0);
            @(negedge clk);
        end
        chk({name, "_done_end"}, n, 32'(done_w[s]), 32'd1);
        chk({name, "_rdy_end"}, n, 32'(rdy_w[s]), 32'd1);
        chk({name, "_tx_end"}, n, 32'(tx_w[s]), 32'd1);
        @(negedge clk);
        chk({name, "_done_clr"}, n + 1, 32'(done_w[s]), 32'd0);
        chk({name, "_tx_idle"}, n + 1, 32'(tx_w[s]), 32'd1);
    endtask

    initial begin
        logic [9:0] f1;
        logic [9:0] f2;
        logic       exp_tx;

        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

        vecs[0] = '{0, 8'hA5, 16'b0000_0011_0100_1010, 10, 0};
        vecs[1] = '{0, 8'h00, 16'b0000_0010_0000_0000, 10, 0};
        vecs[2] = '{0, 8'hFF, 16'b0000_0011_1111_1110, 10, 0};
        vecs[3] = '{0, 8'h3C, 16'b0000_0010_0111_1000, 10, 9};
        vecs[4] = '{1, 8'h07, 16'b0000_0110_0000_1110, 11, 0};
        vecs[5] = '{1, 8'h03, 16'b0000_0100_0000_0110, 11, 0};
        vecs[6] = '{2, 8'h07, 16'b0000_1100_0000_1110, 12, 0};
        vecs[7] = '{2, 8'hA5, 16'b0000_1111_0100_1010, 12, 5};

        // Reset and idle behaviour.
        #1 rst = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx", i, 32'(tx_w[i]), 32'd1);
            chk("rst_rdy", i, 32'(rdy_w[i]), 32'd1);
            chk("rst_done", i, 32'(done_w[i]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("idle_tx", c, 32'(tx_w), 32'h7);
            chk("idle_rdy", c, 32'(rdy_w), 32'h7);
            chk("idle_done", c, 32'(done_w), 32'h0);
        end

        // Table of single frames across the three configurations.
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].sel, vecs[v].data, vecs[v].bits, vecs[v].nbits, vecs[v].poke,
                       $sformatf("vec%0d", v));
        end

        // Back-to-back with tx_valid held: second start bit 41 clocks after the first.
        f1 = 10'b10_1010_1010;
        f2 = 10'b10_0001_1110;
        @(negedge clk);
        valid_v[0] = 1'b1;
        data_v[0]  = 8'h55;
        @(posedge clk);
        for (int j = 0; j <= 82; j++) begin
            @(negedge clk);
            if (j == 5) data_v[0] = 8'h0F;
            if (j == 41) valid_v[0] = 1'b0;
            if (j < 40)       exp_tx = f1[j / BPS];
            else if (j == 40) exp_tx = 1'b1;
            else if (j < 81)  exp_tx = f2[(j - 41) / BPS];
            else              exp_tx = 1'b1;
            chk("b2b_tx", j, 32'(tx_w[0]), 32'(exp_tx));
            chk("b2b_done", j, 32'(done_w[0]), (j == 40 || j == 81) ? 32'd1 : 32'd0);
            if (j != 0 && j != 41)
                chk("b2b_rdy", j, 32'(rdy_w[0]), (j == 40 || j >= 81) ? 32'd1 : 32'd0);
        end

        // Reset during data bit 3 (a 0 bit of 0xA5) releases the line without a clock.
        f1 = 10'b11_0100_1010;
        @(negedge clk);
        valid_v[0] = 1'b1;
        data_v[0]  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        for (int j = 0; j < 18; j++) begin
            if (j > 0) @(negedge clk);
            chk("mid_tx", j, 32'(tx_w[0]), 32'(f1[j / BPS]));
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_tx", 0, 32'(tx_w[0]), 32'd1);
        chk("arst_rdy", 0, 32'(rdy_w[0]), 32'd1);
        chk("arst_done", 0, 32'(done_w[0]), 32'd0);
        @(negedge clk);
        chk("arst_hold_tx", 0, 32'(tx_w[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_tx", 0, 32'(tx_w[0]), 32'd1);
        chk("post_rst_rdy", 0, 32'(rdy_w[0]), 32'd1);
        send_frame(0, 8'h3C, 16'b0000_0010_0111_1000, 10, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
